cu_cond_stage: RTL
==================

// Module: cu_cond_stage
// PURPOSE
//  Execute-stage condition unit downstream of the control-unit main/ALU decoders. Registers decoded
//  control (decode->execute pipeline register), holds architectural NZCV flags, evaluates the
//  4-bit ARM condition field, and gates PC/register/memory writes and flag updates on the result.
// PARAMETERS
//  ALUCTL_W  2  width of ALU control field carried through the stage register
// PORTS
//  clk           in   1         clock, all state updates on rising edge
//  rst_n         in   1         asynchronous active-low reset
//  en            in   1         1 = stage register advances; 0 = stall (hold E contents)
//  flush         in   1         1 = load bubble into E on next edge (priority over en)
//  cond_d        in   4         instruction condition field Instr[31:28]
//  pcs_d         in   1         PC-write request (branch or Rd==R15 write)
//  regw_d        in   1         register-write request from main decoder
//  memw_d        in   1         memory-write request from main decoder
//  memtoreg_d    in   1         writeback select from main decoder
//  alusrc_d      in   1         ALU B-operand select from main decoder
//  flagw_d       in   2         [1]=update N,Z  [0]=update C,V (from ALU decoder)
//  alucontrol_d  in   ALUCTL_W  ALU operation
//  alu_flags_e   in   4         ALU result flags {N,Z,C,V} for instruction in E
//  pcsrc_e       out  1         gated PC write
//  regwrite_e    out  1         gated register write
//  memwrite_e    out  1         gated memory write
//  memtoreg_e    out  1         registered memtoreg (not gated)
//  alusrc_e      out  1         registered alusrc (not gated)
//  alucontrol_e  out  ALUCTL_W  registered alucontrol
//  cond_ex_e     out  1         condition passed and E valid
//  cond_ill_e    out  1         E valid and cond==4'b1111
//  flags_q       out  4         architectural {N,Z,C,V}
// BEHAVIOUR
//  - Reset (async, rst_n=0): valid_e=0, all registered fields 0, flags_q=4'b0000; all outputs 0.
//  - Stage register: flush=1 -> valid_e<=0, all E fields 0 (regardless of en). Else en=1 ->
//    valid_e<=1, capture all *_d. Else hold.
//  - Condition (combinational on cond_e, flags_q): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N;
//    5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V);
//    D LE Z|(N!=V); E AL 1; F -> pass=0, cond_ill_e=valid_e.
//  - cond_ex_e = valid_e & pass. pcsrc_e=pcs_e&cond_ex_e; regwrite_e=regw_e&cond_ex_e;
//    memwrite_e=memw_e&cond_ex_e. Zero latency from E register to outputs.
//  - Flag update on edge when en=1 & cond_ex_e: flagw_e[1] -> N,Z<=alu_flags_e[3:2];
//    flagw_e[0] -> C,V<=alu_flags_e[1:0]; unselected bits hold. No update while en=0 (stalled
//    instruction updates flags once, on the edge it leaves E) or when condition fails.
//  - Next instruction entering E evaluates against flags already written by its predecessor;
//    no forwarding path. Flush and flag update on same edge: flag update of current E still
//    occurs if en=1.
//  - Reset mid-operation: immediate clear of E contents and flags; outputs drop without clock.
//  - Condition evaluated on flags_q only, never on alu_flags_e.
// TESTING
//  1 rst_n=0 with arbitrary inputs -> all outputs 0, flags_q=0000; release, en=0 -> still 0.
//  2 flags_q=0100 (Z), load cond=0000 regw=1 memw=1 -> regwrite_e=1 memwrite_e=1; cond=0001 -> both 0.
//  3 cond=E flagw=10 alu_flags=1011, en=1 -> next flags_q=1000; then flagw=01 alu_flags=0011 -> 1011.
//  4 flags N=1,V=0: cond=A -> cond_ex_e=0; cond=B -> 1; cond=D -> 1; cond=C -> 0.
//  5 instr cond=E pcs=1 in E, flush=1 -> next cycle pcsrc_e=0 cond_ex_e=0, flags unchanged if flagw=00.
//  6 en=0 three cycles with cond=E flagw=11 -> outputs held, flags_q unchanged; en=1 -> single update.
//    cond=F regw=1 -> cond_ill_e=1 regwrite_e=0.

Source files
------------

// File: rtl/cu_cond_stage.sv
// Execute-stage condition unit: decode->execute register, NZCV flags,
// ARM condition evaluation and gating of PC/register/memory writes.
module cu_cond_stage #(
   parameter int ALUCTL_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                flush,
   input  logic [3:0]          cond_d,
   input  logic                pcs_d,
   input  logic                regw_d,
   input  logic                memw_d,
   input  logic                memtoreg_d,
   input  logic                alusrc_d,
   input  logic [1:0]          flagw_d,
   input  logic [ALUCTL_W-1:0] alucontrol_d,
   input  logic [3:0]          alu_flags_e,
   output logic                pcsrc_e,
   output logic                regwrite_e,
   output logic                memwrite_e,
   output logic                memtoreg_e,
   output logic                alusrc_e,
   output logic [ALUCTL_W-1:0] alucontrol_e,
   output logic                cond_ex_e,
   output logic                cond_ill_e,
   output logic [3:0]          flags_q
);

   logic                valid_q;
   logic [3:0]          cond_q;
   logic                pcs_q;
   logic                regw_q;
   logic                memw_q;
   logic                memtoreg_q;
   logic                alusrc_q;
   logic [1:0]          flagw_q;
   logic [ALUCTL_W-1:0] aluctl_q;
   logic [3:0]          flags_d;
   logic                pass;
   logic                n, z, c, v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         cond_q     <= '0;
         pcs_q      <= 1'b0;
         regw_q     <= 1'b0;
         memw_q     <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         flagw_q    <= '0;
         aluctl_q   <= '0;
      end else if (flush) begin
         valid_q    <= 1'b0;
         cond_q     <= '0;
         pcs_q      <= 1'b0;
         regw_q     <= 1'b0;
         memw_q     <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         flagw_q    <= '0;
         aluctl_q   <= '0;
      end else if (en) begin
         valid_q    <= 1'b1;
         cond_q     <= cond_d;
         pcs_q      <= pcs_d;
         regw_q     <= regw_d;
         memw_q     <= memw_d;
         memtoreg_q <= memtoreg_d;
         alusrc_q   <= alusrc_d;
         flagw_q    <= flagw_d;
         aluctl_q   <= alucontrol_d;
      end
   end

   assign n = flags_q[3];
   assign z = flags_q[2];
   assign c = flags_q[1];
   assign v = flags_q[0];

   always_comb begin
      pass = 1'b0;
      case (cond_q)
         4'h0:    pass = z;
         4'h1:    pass = !z;
         4'h2:    pass = c;
         4'h3:    pass = !c;
         4'h4:    pass = n;
         4'h5:    pass = !n;
         4'h6:    pass = v;
         4'h7:    pass = !v;
         4'h8:    pass = c & !z;
         4'h9:    pass = !c | z;
         4'hA:    pass = (n == v);
         4'hB:    pass = (n != v);
         4'hC:    pass = !z & (n == v);
         4'hD:    pass = z | (n != v);
         4'hE:    pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   assign cond_ex_e    = valid_q & pass;
   assign cond_ill_e   = valid_q & (cond_q == 4'hF);
   assign pcsrc_e      = pcs_q & cond_ex_e;
   assign regwrite_e   = regw_q & cond_ex_e;
   assign memwrite_e   = memw_q & cond_ex_e;
   assign memtoreg_e   = memtoreg_q;
   assign alusrc_e     = alusrc_q;
   assign alucontrol_e = aluctl_q;

   // Flags commit only on the edge the instruction leaves E (en=1).
   always_comb begin
      flags_d = flags_q;
      if (en && cond_ex_e) begin
         if (flagw_q[1]) flags_d[3:2] = alu_flags_e[3:2];
         if (flagw_q[0]) flags_d[1:0] = alu_flags_e[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

endmodule
